fifo_big2small_adapter: RTL and testbench
=========================================

# fifo_big2small_adapter

Wide-in, narrow-out first-word-fall-through FIFO with packet framing. Wide words (with a per-word `wr_last` flag) are buffered in a power-of-two-deep FIFO and then serialized into DATA_IN_WIDTH/DATA_OUT_WIDTH narrow slices on the read side. The block is the read-side counterpart of the narrow-to-wide packer used on the ingress path: it drains wide datapath buffers toward narrow consumers such as byte/halfword streams, serializers and register-width ports.

## Interface
- DATA_IN_WIDTH, 128, wide write word width.
- DATA_OUT_WIDTH, 16, narrow read slice width.
  - DATA_IN_WIDTH/DATA_OUT_WIDTH = R, a power of two ≥ 2.
  - R ≥ 2 is checked at elaboration.
- ADDR_WIDTH, 8, FIFO depth = 2**ADDR_WIDTH wide words.
- FULL_SLACK, 1, `wr_full` asserts when `wr_dat_cnt >= 2**ADDR_WIDTH - FULL_SLACK`; 0 = true full.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- wr_ena  in  1  write strobe, one wide word per cycle.
- wr_dat  in  DATA_IN_WIDTH  wide write data.
- wr_last  in  1  word ends a packet.
- wr_full  out  1  FIFO full (slack-adjusted).
- rd_ena  in  1  consume current slice.
- rd_dat  out  DATA_OUT_WIDTH  current slice (FWFT, valid when `!rd_empty`).
- rd_last  out  1  current slice is the final slice of a `wr_last` word.
- rd_empty  out  1  no slice available.
- wr_dat_cnt  out  ADDR_WIDTH+1  wide words in FIFO memory, excluding the word held in the serializer.

## Operation
- **FIFO:**
  - Each entry is DATA_IN_WIDTH+1 bits wide (data plus last flag); read and write pointers are ADDR_WIDTH+1 bits.
  - A write while true-full is dropped; pointers and count are unchanged.
- **Serializer** holds one wide word, its last flag, and a slice index `idx` of log2(R) bits. It has two states:
  - IDLE: `rd_empty=1`. If the FIFO is non-empty, pop one word into the holding register, set `idx=0`, and go to HOLD.
  - HOLD: `rd_empty=0`.
    - `rd_dat` = slice `idx`, where slice k = bits [k*DATA_OUT_WIDTH +: DATA_OUT_WIDTH] (LSB-first).
    - `rd_last` = held last flag AND `idx==R-1`.
    - On `rd_ena` with `idx<R-1`: `idx` increments by 1.
    - On `rd_ena` with `idx==R-1` and FIFO non-empty: pop the next word in the same cycle, `idx=0`, stay in HOLD (no bubble).
    - On `rd_ena` with `idx==R-1` and FIFO empty: go to IDLE.
- `rd_ena` while `rd_empty=1` is ignored.
- A simultaneous write and serializer pop changes `wr_dat_cnt` by 0.
- A write into an empty FIFO while the serializer is IDLE is still registered first; there is no bypass path.
- Data is never reordered or split across packets. `rd_last` marks only packet ends; intermediate words produce R slices with `rd_last=0`.

## Timing
- **Reset (rstn=0):**
  - Pointers, count, `idx` and state are cleared; the state returns to IDLE.
  - `rd_empty=1`, `rd_last=0`, `rd_dat=0`, `wr_full=0` (or 1 if FULL_SLACK ≥ 2**ADDR_WIDTH), `wr_dat_cnt=0`.
  - Reset mid-packet discards all buffered data and the held word.
- **Latency:** a write at edge N into an empty block gives `rd_empty=0` with slice 0 valid after edge N+1.
- **Throughput:** one slice per cycle sustained, with no gap between words while the FIFO is non-empty.
- **Counts:** `wr_dat_cnt` and `wr_full` are registered and update at the edge after the write or pop.
- **Wrap-around:** pointers wrap modulo 2**(ADDR_WIDTH+1). Full is when the pointer MSBs differ and the remaining bits are equal.

## Configuration
- `FIFO_BIG2SMALL_MSB_FIRST_EN`:
  - Defined: slice order is MSB-first, so slice k = bits [(R-1-k)*DATA_OUT_WIDTH +: DATA_OUT_WIDTH]. `rd_last` still marks `idx==R-1` (the LSB slice).
  - Undefined (default): LSB-first as above.
  - All other behaviour and timing are identical.

## Test plan
Configuration for all scenarios: IN=32, OUT=8, ADDR_WIDTH=2, FULL_SLACK=0.
- **Reset:** hold rstn=0 three cycles → `rd_empty=1`, `rd_last=0`, `wr_full=0`, `wr_dat_cnt=0`. Assert rstn=0 mid-packet → same values immediately (asynchronous).
- **Single word:**
  - Stimulus: write 0x44332211 with wr_last=1, then `rd_ena=1` continuously.
  - Response: `rd_empty` falls 1 cycle after the write. `rd_dat` = 0x11, 0x22, 0x33, 0x44 on consecutive cycles. `rd_last=1` only with 0x44, then `rd_empty=1`.
- **Back-to-back:**
  - Stimulus: write 0x03020100 (last=0) and 0x07060504 (last=1), then read continuously.
  - Response: 8 consecutive slices 0x00..0x07 with no bubble; `rd_last` only on 0x07.
- **Full/overflow:**
  - Stimulus: write 4 words with rd_ena=0 → `wr_dat_cnt=3`, because the serializer holds 1 word.
  - Write 1 more → `wr_full=1`, `wr_dat_cnt=4`.
  - Write a 6th word → dropped; a full read-out returns exactly 5 words in order.
- **Stall:** hold rd_ena=0 for 10 cycles mid-word → `rd_dat` and `rd_last` stable. Toggling rd_ena on alternate cycles still yields every slice exactly once.
- **MSB-first:** with `FIFO_BIG2SMALL_MSB_FIRST_EN` defined, 0x44332211 (last=1) reads 0x44, 0x33, 0x22, 0x11, with `rd_last` on 0x11.

Source files
------------

// File: rtl/fifo_big2small_adapter.sv
// ---------------------------------------------------------------------------
// fifo_big2small_adapter
//
// Wide-in, narrow-out first-word-fall-through FIFO with packet framing.
// Wide words, each with a packet-end flag, are stored in a 2**ADDR_WIDTH deep
// FIFO. A one-word serializer then presents them as R = DATA_IN_WIDTH /
// DATA_OUT_WIDTH narrow slices on the read side.
//
// Parameters:
//   DATA_IN_WIDTH  - wide write word width
//   DATA_OUT_WIDTH - narrow read slice width (the ratio R must be a power of two >= 2)
//   ADDR_WIDTH     - FIFO depth is 2**ADDR_WIDTH wide words
//   FULL_SLACK     - wr_full asserts at wr_dat_cnt >= 2**ADDR_WIDTH - FULL_SLACK
//
// Ports:
//   clk        - single clock, rising edge
//   rstn       - asynchronous active-low reset
//   wr_ena     - write strobe, one wide word per cycle
//   wr_dat     - wide write data
//   wr_last    - the written word ends a packet
//   wr_full    - FIFO full, slack-adjusted (registered)
//   rd_ena     - consume the current slice
//   rd_dat     - current slice (FWFT, valid while !rd_empty)
//   rd_last    - current slice is the final slice of a packet-end word
//   rd_empty   - no slice available
//   wr_dat_cnt - wide words in FIFO memory, not counting the serializer word
//
// Build option:
//   FIFO_BIG2SMALL_MSB_FIRST_EN - when defined, slices are emitted MSB-first.
//                                 rd_last still marks the final slice, which is
//                                 then the least significant one.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module fifo_big2small_adapter #(
    parameter int DATA_IN_WIDTH  = 128,
    parameter int DATA_OUT_WIDTH = 16,
    parameter int ADDR_WIDTH     = 8,
    parameter int FULL_SLACK     = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      wr_ena,
    input  logic [DATA_IN_WIDTH-1:0]  wr_dat,
    input  logic                      wr_last,
    output logic                      wr_full,
    input  logic                      rd_ena,
    output logic [DATA_OUT_WIDTH-1:0] rd_dat,
    output logic                      rd_last,
    output logic                      rd_empty,
    output logic [ADDR_WIDTH:0]       wr_dat_cnt
);

    localparam int RATIO   = DATA_IN_WIDTH / DATA_OUT_WIDTH;
    localparam int IDX_W   = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam int ENTRY_W = DATA_IN_WIDTH + 1;

    // Count at which wr_full asserts; a slack at or beyond the depth pins it high.
    localparam int FULL_THRESH = (FULL_SLACK >= DEPTH) ? 0 : DEPTH - FULL_SLACK;
    localparam logic [ADDR_WIDTH+1:0] FULL_THRESH_V = (ADDR_WIDTH + 2)'(FULL_THRESH);
    localparam logic                  FULL_AT_RESET = (FULL_THRESH == 0);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]    IDX_ONE = IDX_W'(1);
    localparam logic [IDX_W-1:0]    IDX_MAX = IDX_W'(RATIO - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    generate
        if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 ||
            RATIO * DATA_OUT_WIDTH != DATA_IN_WIDTH) begin : g_bad_ratio
            $error("fifo_big2small_adapter: DATA_IN_WIDTH/DATA_OUT_WIDTH must be a power of two >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0]        mem [DEPTH];

    logic [ADDR_WIDTH:0]       wr_ptr_reg;
    logic [ADDR_WIDTH:0]       rd_ptr_reg;
    logic [ADDR_WIDTH:0]       cnt_reg;
    logic [ADDR_WIDTH:0]       cnt_next;
    logic                      full_reg;
    logic                      full_next;
    logic [0:0]                state_reg;
    logic [0:0]                state_next;
    logic [IDX_W-1:0]          idx_reg;
    logic [IDX_W-1:0]          idx_next;
    logic [DATA_IN_WIDTH-1:0]  hold_data_reg;
    logic                      hold_last_reg;

    logic                      fifo_empty;
    logic                      fifo_full_true;
    logic                      wr_accept;
    logic                      word_done;
    logic                      pop;

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    assign fifo_empty     = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full_true = (wr_ptr_reg[ADDR_WIDTH] != rd_ptr_reg[ADDR_WIDTH]) &&
                            (wr_ptr_reg[ADDR_WIDTH-1:0] == rd_ptr_reg[ADDR_WIDTH-1:0]);

    // Writes into a truly full FIFO are dropped; the slack only affects wr_full.
    assign wr_accept = wr_ena && !fifo_full_true;

    // The serializer pulls a word either when it is idle or when the last
    // slice of the held word is being consumed (back-to-back, no bubble).
    assign word_done = (state_reg == ST_HOLD) && rd_ena && (idx_reg == IDX_MAX);
    assign pop       = !fifo_empty && ((state_reg == ST_IDLE) || word_done);

    always_comb begin
        cnt_next = cnt_reg;
        case ({wr_accept, pop})
            2'b10:   cnt_next = cnt_reg + PTR_ONE;
            2'b01:   cnt_next = cnt_reg - PTR_ONE;
            default: cnt_next = cnt_reg;
        endcase
    end

    assign full_next = ({1'b0, cnt_next} >= FULL_THRESH_V);

    // ------------------------------------------------------------------
    // Serializer state machine
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_next = ST_HOLD;
                    idx_next   = '0;
                end
            end
            default: begin
                if (rd_ena) begin
                    if (idx_reg != IDX_MAX) begin
                        idx_next = idx_reg + IDX_ONE;
                    end else if (!fifo_empty) begin
                        idx_next = '0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
            full_reg   <= FULL_AT_RESET;
            state_reg  <= ST_IDLE;
            idx_reg    <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            cnt_reg   <= cnt_next;
            full_reg  <= full_next;
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Memory array and its registered read port carry no reset so they map
    // onto block RAM. The held word is only visible while in HOLD, so its
    // power-up contents never reach the outputs.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= {wr_last, wr_dat};
        end
        if (pop) begin
            {hold_last_reg, hold_data_reg} <= mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Slice selection
    // ------------------------------------------------------------------
    logic [DATA_OUT_WIDTH-1:0] slices [RATIO];

    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
`ifdef FIFO_BIG2SMALL_MSB_FIRST_EN
            localparam int POS = RATIO - 1 - gi;
`else
            localparam int POS = gi;
`endif
            assign slices[gi] = hold_data_reg[POS*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
        end
    endgenerate

    assign rd_empty   = (state_reg == ST_IDLE);
    assign rd_dat     = (state_reg == ST_HOLD) ? slices[idx_reg] : '0;
    assign rd_last    = (state_reg == ST_HOLD) && hold_last_reg && (idx_reg == IDX_MAX);
    assign wr_full    = full_reg;
    assign wr_dat_cnt = cnt_reg;

endmodule

// File: tb/tb_fifo_big2small_adapter.sv
`timescale 1ns/1ps

module tb_fifo_big2small_adapter;

    logic        clk;
    logic        rstn;
    logic        wr_ena;
    logic [31:0] wr_dat;
    logic        wr_last;
    logic        wr_full;
    logic        rd_ena;
    logic [7:0]  rd_dat;
    logic        rd_last;
    logic        rd_empty;
    logic [2:0]  wr_dat_cnt;

    int cmp_count  = 0;
    int fail_count = 0;

    fifo_big2small_adapter #(
        .DATA_IN_WIDTH (32),
        .DATA_OUT_WIDTH(8),
        .ADDR_WIDTH    (2),
        .FULL_SLACK    (0)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .wr_ena    (wr_ena),
        .wr_dat    (wr_dat),
        .wr_last   (wr_last),
        .wr_full   (wr_full),
        .rd_ena    (rd_ena),
        .rd_dat    (rd_dat),
        .rd_last   (rd_last),
        .rd_empty  (rd_empty),
        .wr_dat_cnt(wr_dat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected slice k of a 32-bit word in emission order.
    function automatic logic [7:0] exp_slice(input logic [31:0] w, input int k);
`ifdef FIFO_BIG2SMALL_MSB_FIRST_EN
        return w[(3 - k)*8 +: 8];
`else
        return w[k*8 +: 8];
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %-16s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reads one wide word as four slices; rd_ena must already be high.
    task automatic read_word(input logic [31:0] w, input logic last, input string tag);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_empty%0d", tag, k), rd_empty, 1'b0);
            check($sformatf("%s_dat%0d", tag, k), rd_dat, exp_slice(w, k));
            check($sformatf("%s_last%0d", tag, k), rd_last, last && (k == 3));
            tick();
        end
    endtask

    logic [31:0] fw [6];

    initial begin
        rstn    = 1'b0;
        wr_ena  = 1'b0;
        wr_dat  = '0;
        wr_last = 1'b0;
        rd_ena  = 1'b0;
        fw[0] = 32'hA3A2A1A0;
        fw[1] = 32'hB3B2B1B0;
        fw[2] = 32'hC3C2C1C0;
        fw[3] = 32'hD3D2D1D0;
        fw[4] = 32'hE3E2E1E0;
        fw[5] = 32'hF3F2F1F0;

        // Reset held for three cycles
        repeat (3) tick();
        check("rst_empty", rd_empty, 1'b1);
        check("rst_last", rd_last, 1'b0);
        check("rst_full", wr_full, 1'b0);
        check("rst_cnt", wr_dat_cnt, 3'd0);
        check("rst_dat", rd_dat, 8'h00);
        rstn = 1'b1;
        tick();

        // Single word; rd_ena high early is ignored while empty
        rd_ena  = 1'b1;
        wr_ena  = 1'b1;
        wr_dat  = 32'h44332211;
        wr_last = 1'b1;
        tick();
        wr_ena  = 1'b0;
        wr_last = 1'b0;
        check("sw_empty_n", rd_empty, 1'b1);
        check("sw_cnt_n", wr_dat_cnt, 3'd1);
        tick();
        check("sw_cnt_n1", wr_dat_cnt, 3'd0);
        read_word(32'h44332211, 1'b1, "sw");
        check("sw_drained", rd_empty, 1'b1);
        check("sw_last_off", rd_last, 1'b0);
        rd_ena = 1'b0;

        // Back-to-back words, no bubble
        wr_ena  = 1'b1;
        wr_dat  = 32'h03020100;
        wr_last = 1'b0;
        tick();
        wr_dat  = 32'h07060504;
        wr_last = 1'b1;
        tick();
        wr_ena  = 1'b0;
        wr_last = 1'b0;
        check("b2b_cnt", wr_dat_cnt, 3'd1);
        rd_ena = 1'b1;
        read_word(32'h03020100, 1'b0, "b2b0");
        read_word(32'h07060504, 1'b1, "b2b1");
        check("b2b_drained", rd_empty, 1'b1);
        rd_ena = 1'b0;

        // Fill, full flag, overflow drop
        for (int i = 0; i < 4; i++) begin
            wr_ena  = 1'b1;
            wr_dat  = fw[i];
            wr_last = 1'b0;
            tick();
        end
        wr_ena = 1'b0;
        check("fill4_cnt", wr_dat_cnt, 3'd3);
        check("fill4_full", wr_full, 1'b0);
        check("fill4_empty", rd_empty, 1'b0);
        wr_ena  = 1'b1;
        wr_dat  = fw[4];
        wr_last = 1'b1;
        tick();
        check("fill5_cnt", wr_dat_cnt, 3'd4);
        check("fill5_full", wr_full, 1'b1);
        wr_dat  = fw[5];
        wr_last = 1'b0;
        tick();
        wr_ena = 1'b0;
        check("ovf_cnt", wr_dat_cnt, 3'd4);
        check("ovf_full", wr_full, 1'b1);
        check("ovf_head", rd_dat, exp_slice(fw[0], 0));
        rd_ena = 1'b1;
        for (int i = 0; i < 5; i++) begin
            read_word(fw[i], (i == 4), $sformatf("ovf_w%0d", i));
        end
        check("ovf_drained", rd_empty, 1'b1);
        check("ovf_cnt_end", wr_dat_cnt, 3'd0);
        check("ovf_full_end", wr_full, 1'b0);
        rd_ena = 1'b0;

        // Stall: alternate rd_ena, then hold the final slice for 10 cycles
        wr_ena  = 1'b1;
        wr_dat  = 32'hDDCCBBAA;
        wr_last = 1'b1;
        tick();
        wr_ena  = 1'b0;
        wr_last = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("alt_dat%0d", k), rd_dat, exp_slice(32'hDDCCBBAA, k));
            check($sformatf("alt_last%0d", k), rd_last, 1'b0);
            rd_ena = 1'b1;
            tick();
            rd_ena = 1'b0;
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            check($sformatf("stall_dat%0d", c), rd_dat, exp_slice(32'hDDCCBBAA, 3));
            check($sformatf("stall_last%0d", c), rd_last, 1'b1);
            tick();
        end
        rd_ena = 1'b1;
        tick();
        rd_ena = 1'b0;
        check("stall_drained", rd_empty, 1'b1);

        // Asynchronous reset mid-packet
        wr_ena  = 1'b1;
        wr_dat  = 32'h0D0C0B0A;
        wr_last = 1'b1;
        tick();
        wr_dat  = 32'h1D1C1B1A;
        wr_last = 1'b0;
        tick();
        wr_ena = 1'b0;
        rd_ena = 1'b1;
        tick();
        rd_ena = 1'b0;
        check("arst_pre_dat", rd_dat, exp_slice(32'h0D0C0B0A, 1));
        check("arst_pre_cnt", wr_dat_cnt, 3'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_empty", rd_empty, 1'b1);
        check("arst_last", rd_last, 1'b0);
        check("arst_full", wr_full, 1'b0);
        check("arst_cnt", wr_dat_cnt, 3'd0);
        check("arst_dat", rd_dat, 8'h00);
        tick();
        rstn = 1'b1;
        tick();
        tick();
        check("arst_discard_e", rd_empty, 1'b1);
        check("arst_discard_c", wr_dat_cnt, 3'd0);

        // Recovery after reset
        wr_ena  = 1'b1;
        wr_dat  = 32'h89ABCDEF;
        wr_last = 1'b1;
        tick();
        wr_ena  = 1'b0;
        wr_last = 1'b0;
        tick();
        rd_ena = 1'b1;
        read_word(32'h89ABCDEF, 1'b1, "rec");
        check("rec_drained", rd_empty, 1'b1);
        rd_ena = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
